// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order retirement buffer. Instructions allocate an entry at the
// tail when issued, receive their result from the common data bus (CDB), and
// retire from the head in program order once their result is present.
//
// Ports
//   clk              sole clock, rising edge
//   reset            asynchronous active-high reset (control state only)
//   flush            synchronous misprediction flush, beats every other action
//   issue            allocate one entry (ignored while issue_ready=0)
//   issue_arch_num   destination register of the issuing instruction
//   issue_ready      buffer not full
//   issue_tag        tag the next issue receives (tail pointer)
//   cdb_valid        result broadcast valid
//   cdb_tag          tag of the broadcast result
//   cdb_data         broadcast result value
//   read_tag[2]      operand lookup tags
//   read_done[2]     looked-up entry holds a result (with CDB bypass)
//   read_data[2]     looked-up result value (with CDB bypass)
//   commit           head entry retires this cycle
//   commit_arch_num  destination register of the retiring entry
//   commit_tag       tag of the retiring entry (head pointer)
//   commit_data      result of the retiring entry
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH = 3,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue,
    input  logic [REG_WIDTH-1:0] issue_arch_num,
    output logic                 issue_ready,
    output logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    input  logic [ROB_WIDTH-1:0] read_tag  [2],
    output logic                 read_done [2],
    output logic [31:0]          read_data [2],
    output logic                 commit,
    output logic [REG_WIDTH-1:0] commit_arch_num,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          commit_data
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ROB_WIDTH;

    localparam logic [ROB_WIDTH:0]   DEPTH_CNT = (ROB_WIDTH + 1)'(DEPTH);
    localparam logic [ROB_WIDTH:0]   CNT_ONE   = (ROB_WIDTH + 1)'(1);
    localparam logic [ROB_WIDTH:0]   CNT_ZERO  = '0;
    localparam logic [ROB_WIDTH-1:0] PTR_ONE   = ROB_WIDTH'(1);

    // Control state
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     done;

    // Payload state (never reset; qualified by busy/done)
    logic [REG_WIDTH-1:0] arch_num [DEPTH];
    logic [DATA_W-1:0]    data     [DEPTH];

    logic issue_acc;
    logic cdb_hit;

    // Fullness is judged on the registered count only, so a slot freed by a
    // retire this cycle is not reusable until the next cycle.
    assign issue_ready = (count < DEPTH_CNT);
    assign issue_tag   = tail;
    assign issue_acc   = issue && issue_ready;

    // A broadcast is only meaningful for an allocated entry; stale tags drop.
    assign cdb_hit     = cdb_valid && busy[cdb_tag];

    // Retire uses registered done only, which gives the one-cycle
    // write-to-retire latency after a CDB write to the head entry.
    assign commit          = (count != CNT_ZERO) && done[head] && !flush;
    assign commit_tag      = head;
    assign commit_arch_num = arch_num[head];
    assign commit_data     = data[head];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            read_done[i] = done[read_tag[i]];
            read_data[i] = data[read_tag[i]];
            if (cdb_hit && (cdb_tag == read_tag[i])) begin
                read_done[i] = 1'b1;
                read_data[i] = cdb_data;
            end
        end
    end

    // Control registers: pointers, occupancy and per-entry status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else begin
            if (issue_acc) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + PTR_ONE;
            end
            if (cdb_hit) begin
                done[cdb_tag] <= 1'b1;
            end
            // Retire clears last so it wins over a redundant CDB to the head.
            if (commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + PTR_ONE;
            end
            case ({issue_acc, commit})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload registers: written without reset, harmless under flush
    always_ff @(posedge clk) begin
        if (issue_acc) begin
            arch_num[tail] <= issue_arch_num;
        end
        if (cdb_hit) begin
            data[cdb_tag] <= cdb_data;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Scoreboard bench for reorder_buffer (ROB_WIDTH=3, REG_WIDTH=5). Accepted
// issues push {tag, arch} into an in-order queue; CDB writes record the
// expected result per tag; every observed commit pops the queue front and is
// compared against it. Directed checks cover reset, full/ready timing, wrap,
// CDB bypass, flush priority and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        issue;
    logic [4:0]  issue_arch_num;
    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  read_tag  [2];
    logic        read_done [2];
    logic [31:0] read_data [2];
    logic        commit;
    logic [4:0]  commit_arch_num;
    logic [2:0]  commit_tag;
    logic [31:0] commit_data;

    typedef struct packed {
        logic [2:0] tag;
        logic [4:0] arch;
    } sb_t;

    sb_t         sb_q [$];
    logic [31:0] exp_data [8];
    logic [2:0]  exp_tail;
    int          total;
    int          bad;

    reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .issue           (issue),
        .issue_arch_num  (issue_arch_num),
        .issue_ready     (issue_ready),
        .issue_tag       (issue_tag),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .read_tag        (read_tag),
        .read_done       (read_done),
        .read_data       (read_data),
        .commit          (commit),
        .commit_arch_num (commit_arch_num),
        .commit_tag      (commit_tag),
        .commit_data     (commit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Commit monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("commit_unexpected", 1, 0);
            end else begin
                sb_t f;
                f = sb_q.pop_front();
                chk("commit_tag", commit_tag, f.tag);
                chk("commit_arch", commit_arch_num, f.arch);
                chk("commit_data", commit_data, exp_data[f.tag]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        chk("rst_commit", commit, 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_tag", issue_tag, 0);
        tick;
        tick;
        reset = 1'b0;
        sb_q.delete();
        exp_tail = '0;
    endtask

    task automatic issue_op(input logic [4:0] arch);
        chk("issue_ready", issue_ready, 1);
        chk("issue_tag", issue_tag, exp_tail);
        issue          = 1'b1;
        issue_arch_num = arch;
        sb_q.push_back('{tag: exp_tail, arch: arch});
        exp_tail       = exp_tail + 3'd1;
        tick;
        issue = 1'b0;
    endtask

    task automatic cdb_op(input logic [2:0] tag, input logic [31:0] d);
        exp_data[tag] = d;
        cdb_valid     = 1'b1;
        cdb_tag       = tag;
        cdb_data      = d;
        tick;
        cdb_valid = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick;
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        flush = 1'b0;
        issue = 1'b0;
        issue_arch_num = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        read_tag[0] = 3'd0;
        read_tag[1] = 3'd1;
        exp_tail = '0;
        for (int i = 0; i < 8; i++) exp_data[i] = '0;

        // Reset state
        do_reset;
        chk("rst_rd0", read_done[0], 0);
        chk("rst_rd1", read_done[1], 0);

        // Basic in-order retire with out-of-order completion
        issue_op(5'd5);
        issue_op(5'd7);
        cdb_op(3'd1, 32'h22);
        chk("no_commit_tail_done", commit, 0);
        exp_data[0] = 32'h11;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd0;
        cdb_data  = 32'h11;
        #1;
        chk("no_same_cycle_retire", commit, 0);
        tick;
        cdb_valid = 1'b0;
        chk("retire_next_cycle", commit, 1);
        chk("retire_tag0", commit_tag, 0);
        tick;
        chk("retire_tag1", commit_tag, 1);
        chk("retire_arch1", commit_arch_num, 7);
        drain;

        // Full buffer, ignored issue, ready after retire
        do_reset;
        for (int i = 0; i < 8; i++) issue_op(5'(10 + i));
        chk("full_ready", issue_ready, 0);
        issue = 1'b1;
        issue_arch_num = 5'd31;
        tick;
        issue = 1'b0;
        chk("full_tag", issue_tag, 0);
        chk("full_ready2", issue_ready, 0);
        cdb_op(3'd0, 32'h55);
        chk("full_commit", commit, 1);
        chk("ready_not_in_retire_cycle", issue_ready, 0);
        tick;
        chk("ready_after_retire", issue_ready, 1);
        chk("no_commit_head1", commit, 0);

        // Pointer wrap
        do_reset;
        for (int i = 0; i < 7; i++) issue_op(5'(1 + i));
        for (int i = 0; i < 7; i++) cdb_op(3'(i), 32'h100 + i);
        drain;
        issue_op(5'd20);
        issue_op(5'd21);
        cdb_op(3'd0, 32'hA0);
        chk("wrap_hold", commit, 0);
        cdb_op(3'd7, 32'hA7);
        chk("wrap_commit7", commit_tag, 7);
        drain;

        // Same-cycle CDB bypass on lookup
        do_reset;
        for (int i = 0; i < 3; i++) issue_op(5'(2 + i));
        read_tag[0] = 3'd2;
        read_tag[1] = 3'd1;
        exp_data[2] = 32'hABCD;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd2;
        cdb_data  = 32'hABCD;
        #1;
        chk("byp_done", read_done[0], 1);
        chk("byp_data", read_data[0], 32'hABCD);
        chk("byp_other", read_done[1], 0);
        tick;
        cdb_valid = 1'b0;
        #1;
        chk("byp_later_done", read_done[0], 1);
        chk("byp_later_data", read_data[0], 32'hABCD);

        // Flush beats commit and issue
        cdb_op(3'd0, 32'h33);
        flush = 1'b1;
        issue = 1'b1;
        issue_arch_num = 5'd9;
        #1;
        chk("flush_commit", commit, 0);
        tick;
        flush = 1'b0;
        issue = 1'b0;
        sb_q.delete();
        exp_tail = '0;
        chk("flush_tag", issue_tag, 0);
        chk("flush_commit2", commit, 0);
        chk("flush_ready", issue_ready, 1);
        chk("flush_rd", read_done[0], 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) issue_op(5'(6 + i));
        cdb_op(3'd0, 32'h77);
        read_tag[0] = 3'd0;
        #1;
        chk("pre_rst_commit", commit, 1);
        chk("pre_rst_rd", read_done[0], 1);
        reset = 1'b1;
        #1;
        chk("arst_commit", commit, 0);
        chk("arst_ready", issue_ready, 1);
        chk("arst_tag", issue_tag, 0);
        chk("arst_rd", read_done[0], 0);
        sb_q.delete();
        exp_tail = '0;
        tick;
        reset = 1'b0;
        read_tag[0] = 3'd1;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd1;
        cdb_data  = 32'h99;
        #1;
        chk("stale_byp", read_done[0], 0);
        tick;
        cdb_valid = 1'b0;
        chk("stale_rd", read_done[0], 0);
        chk("stale_commit", commit, 0);
        issue_op(5'd3);
        chk("post_rst_tail", issue_tag, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_WIDTH, 3, tag width; depth DEPTH = 2**ROB_WIDTH entries.
REQ-002 Parameter REG_WIDTH, 5, architectural register number width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous misprediction flush; empties the buffer.
REQ-006 issue  input  1  allocate one entry this cycle; honoured only when issue_ready=1.
REQ-007 issue_arch_num  input  REG_WIDTH  destination register of the issuing instruction.
REQ-008 issue_ready  output  1  buffer not full.
REQ-009 issue_tag  output  ROB_WIDTH  tag the next issue receives; equals the tail pointer.
REQ-010 cdb_valid  input  1  result broadcast valid.
REQ-011 cdb_tag  input  ROB_WIDTH  tag of the broadcast result.
REQ-012 cdb_data  input  32  broadcast result value.
REQ-013 read_tag[2]  input  ROB_WIDTH each  operand lookup tags from the register file.
REQ-014 read_done[2]  output  1 each  looked-up entry holds a result.
REQ-015 read_data[2]  output  32 each  looked-up result value.
REQ-016 commit  output  1  head entry retires this cycle.
REQ-017 commit_arch_num  output  REG_WIDTH  destination register of the retiring entry.
REQ-018 commit_tag  output  ROB_WIDTH  tag of the retiring entry; equals the head pointer.
REQ-019 commit_data  output  32  result of the retiring entry.

Function
REQ-020 State: head, tail (ROB_WIDTH bits, wrap mod DEPTH), count (ROB_WIDTH+1 bits), per entry {busy, done, arch_num, data}.
REQ-021 issue_ready SHALL be (count < DEPTH) and SHALL NOT depend on same-cycle commit (no slot reuse in the freeing cycle).
REQ-022 On issue && issue_ready: entry[tail] <= {busy=1, done=0, arch_num=issue_arch_num}; tail <= tail+1 with wrap DEPTH-1 -> 0.
REQ-023 issue while issue_ready=0 SHALL be ignored with no state change.
REQ-024 On cdb_valid with entry[cdb_tag].busy=1: done <= 1, data <= cdb_data; cdb_valid to a non-busy entry SHALL be ignored.
REQ-025 commit SHALL be combinational: count != 0 && entry[head].done && !flush; commit_* fields are driven from entry[head].
REQ-026 On commit: entry[head].busy <= 0, done <= 0; head <= head+1 with wrap.
REQ-027 count <= count + (issue accepted) - commit; simultaneous accepted issue and commit leaves count unchanged.
REQ-028 A CDB write to the head entry makes commit rise the following cycle (one-cycle write-to-retire latency, no same-cycle retire).
REQ-029 read_done[i] = entry[read_tag[i]].done, or 1 if cdb_valid && cdb_tag == read_tag[i] && entry busy (same-cycle bypass); read_data[i] follows the same selection, bypass taking priority.
REQ-030 flush SHALL take priority over issue, CDB write and commit in the same cycle: all busy/done <= 0, head <= 0, tail <= 0, count <= 0.
REQ-031 Entry data and arch_num need not be cleared on flush or reset; read_data/commit_data are don't-care when the matching done/commit bit is 0.

Reset
REQ-032 reset SHALL, without a clock edge, force head=0, tail=0, count=0, all busy=0, done=0.
REQ-033 During and after reset: commit=0, issue_ready=1, issue_tag=0, read_done=0 unless a CDB bypass hits a busy entry (none exists after reset).
REQ-034 Reset deasserted mid-operation SHALL discard all in-flight entries; the first post-reset issue receives tag 0.

Verification (ROB_WIDTH=3)
REQ-035 Reset, issue arch 5, 7 over two cycles -> tags 0, 1; CDB tag1 data 0x22 then tag0 data 0x11 -> commit tag0 arch5 0x11, next cycle commit tag1 arch7 0x22, in order.
REQ-036 Issue 8 entries with no CDB -> issue_ready=0 after the eighth; ninth issue ignored, issue_tag stays 0; complete and retire tag0 -> issue_ready=1 the next cycle, not the retire cycle.
REQ-037 Wrap: retire/issue until tail=7, issue twice -> tags 7 then 0; both retire in order 7, 0.
REQ-038 read_tag[0]=2 with cdb_valid, cdb_tag=2, data 0xABCD on busy entry 2 -> read_done[0]=1, read_data[0]=0xABCD same cycle; entry 2 then reads done in later cycles.
REQ-039 Flush asserted with head entry done and issue=1 -> commit=0 that cycle; next cycle count=0, issue_tag=0, commit=0.
REQ-040 Assert reset asynchronously between edges with 4 busy entries -> outputs reach reset values before next posedge; CDB to an old tag afterwards changes nothing.
